// File: rtl/monitor_bus_initiator.sv
// Host-side initiator for the monitor option-slot bus: runs one SYNC/CMD/REG/DATA/TERM
// transaction per request and synchronises the card interrupt line.
module monitor_bus_initiator #(
  parameter int HALF_PERIOD = 25
) (
  input  logic       clk_50mhz_in,
  input  logic       strobe_irq_clr,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_init,
  input  logic [7:0] req_cmd,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       clk_rw,
  output logic       ax_d,
  output logic       r_wx,
  output logic       slot_x_int_x,
  output logic [7:0] bus_out_x,
  output logic       bus_oe_x,
  input  logic [7:0] bus_in_x,
  input  logic       int_x,
  output logic       irq_pending
);

  localparam int CW = $clog2(2 * HALF_PERIOD);
  localparam logic [CW-1:0] HP_C   = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] LAST_C = CW'(2 * HALF_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CMD, S_REG, S_DATA, S_TERM} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          lat_write, lat_write_n, lat_init, lat_init_n;
  logic [7:0]    lat_cmd, lat_cmd_n, lat_reg, lat_reg_n, lat_wdata, lat_wdata_n;
  logic          rsp_valid_n;
  logic [7:0]    rsp_rdata_n;
  logic          clk_rw_n, ax_d_n, r_wx_n, slot_x_int_x_n, bus_oe_x_n;
  logic [7:0]    bus_out_x_n;
  logic          sync1, sync2;

  assign req_ready   = (state == S_IDLE) && !rsp_valid;
  assign busy        = !req_ready;
  assign irq_pending = !sync2;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lat_write_n = lat_write;
    lat_init_n  = lat_init;
    lat_cmd_n   = lat_cmd;
    lat_reg_n   = lat_reg;
    lat_wdata_n = lat_wdata;
    rsp_valid_n = 1'b0;
    rsp_rdata_n = rsp_rdata;

    if (state == S_IDLE) begin
      cnt_n = '0;
      if (req_valid && req_ready) begin
        state_n     = S_SYNC;
        lat_write_n = req_write;
        lat_init_n  = req_init;
        lat_cmd_n   = req_cmd;
        lat_reg_n   = req_reg;
        lat_wdata_n = req_wdata;
      end
    end else if (cnt == LAST_C) begin
      cnt_n = '0;
      unique case (state)
        S_SYNC:  state_n = S_CMD;
        S_CMD:   state_n = S_REG;
        S_REG:   state_n = S_DATA;
        S_DATA:  state_n = S_TERM;
        default: begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b1;
          if (lat_write) rsp_rdata_n = 8'hFF;
        end
      endcase
    end else begin
      cnt_n = cnt + CW'(1);
    end

    // Read data is taken at the clk_rw rising edge of the DATA cycle.
    if (state == S_DATA && !lat_write && cnt == HP_C) rsp_rdata_n = ~bus_in_x;

    // Phase outputs are derived from the upcoming state so they are registered.
    clk_rw_n       = (state_n == S_IDLE) ? 1'b1 : (cnt_n >= HP_C);
    ax_d_n         = 1'b1;
    r_wx_n         = 1'b1;
    slot_x_int_x_n = (state_n == S_IDLE) ? 1'b1 : !lat_init_n;
    bus_oe_x_n     = 1'b0;
    bus_out_x_n    = 8'h00;
    unique case (state_n)
      S_IDLE: begin
        bus_oe_x_n  = 1'b1;
        bus_out_x_n = 8'hFF;
      end
      S_SYNC: ax_d_n = 1'b0;
      S_CMD: begin
        ax_d_n      = 1'b0;
        r_wx_n      = 1'b0;
        bus_out_x_n = ~lat_cmd_n;
      end
      S_REG: begin
        r_wx_n      = 1'b0;
        bus_out_x_n = ~lat_reg_n;
      end
      S_DATA: begin
        r_wx_n      = !lat_write_n;
        bus_oe_x_n  = !lat_write_n;
        bus_out_x_n = lat_write_n ? ~lat_wdata_n : 8'hFF;
      end
      default: ax_d_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk_50mhz_in or posedge strobe_irq_clr) begin
    if (strobe_irq_clr) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lat_write    <= 1'b0;
      lat_init     <= 1'b0;
      lat_cmd      <= 8'h00;
      lat_reg      <= 8'h00;
      lat_wdata    <= 8'h00;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 8'h00;
      clk_rw       <= 1'b1;
      ax_d         <= 1'b1;
      r_wx         <= 1'b1;
      slot_x_int_x <= 1'b1;
      bus_oe_x     <= 1'b1;
      bus_out_x    <= 8'hFF;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      lat_write    <= lat_write_n;
      lat_init     <= lat_init_n;
      lat_cmd      <= lat_cmd_n;
      lat_reg      <= lat_reg_n;
      lat_wdata    <= lat_wdata_n;
      rsp_valid    <= rsp_valid_n;
      rsp_rdata    <= rsp_rdata_n;
      clk_rw       <= clk_rw_n;
      ax_d         <= ax_d_n;
      r_wx         <= r_wx_n;
      slot_x_int_x <= slot_x_int_x_n;
      bus_oe_x     <= bus_oe_x_n;
      bus_out_x    <= bus_out_x_n;
      sync1        <= int_x;
      sync2        <= sync1;
    end
  end

endmodule

// File: tb/tb_monitor_bus_initiator.sv
// Bench for monitor_bus_initiator: directed and random transactions checked cycle by
// cycle against a bus-cycle model computed from the transaction fields.
module tb_monitor_bus_initiator;

  localparam int HP = 25;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_write, req_init;
  logic [7:0] req_cmd, req_reg, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy, clk_rw, ax_d, r_wx, slot_x_int_x, bus_oe_x;
  logic [7:0] bus_out_x, bus_in_x;
  logic       int_x, irq_pending;

  int checks = 0;
  int errors = 0;

  monitor_bus_initiator #(.HALF_PERIOD(HP)) dut (
    .clk_50mhz_in(clk), .strobe_irq_clr(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_init(req_init), .req_cmd(req_cmd), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .clk_rw(clk_rw), .ax_d(ax_d), .r_wx(r_wx), .slot_x_int_x(slot_x_int_x),
    .bus_out_x(bus_out_x), .bus_oe_x(bus_oe_x), .bus_in_x(bus_in_x),
    .int_x(int_x), .irq_pending(irq_pending)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_clk_rw"}, {7'd0, clk_rw}, 8'd1);
    chk({tag, "_ax_d"}, {7'd0, ax_d}, 8'd1);
    chk({tag, "_r_wx"}, {7'd0, r_wx}, 8'd1);
    chk({tag, "_slot"}, {7'd0, slot_x_int_x}, 8'd1);
    chk({tag, "_oe"}, {7'd0, bus_oe_x}, 8'd1);
    chk({tag, "_out"}, bus_out_x, 8'hFF);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a clock edge with the DUT idle and ready; returns at the first ready cycle after the response.
  task automatic run_txn(input logic w, input logic init, input logic [7:0] cmd,
                         input logic [7:0] rg, input logic [7:0] wd, input logic [7:0] card,
                         input bit keep_valid);
    logic [7:0] bytes [5];
    logic [7:0] exp_rd;
    int b, ph;
    logic drive;
    bytes  = '{8'hFF, cmd, rg, wd, 8'hFF};
    exp_rd = w ? 8'hFF : card;
    req_write = w; req_init = init; req_cmd = cmd; req_reg = rg; req_wdata = wd;
    req_valid = 1'b1;
    chk("ready_before", {7'd0, req_ready}, 8'd1);
    step();
    if (!keep_valid) req_valid = 1'b0;
    for (int c = 1; c <= 10 * HP; c++) begin
      b  = (c - 1) / (2 * HP);
      ph = (c - 1) % (2 * HP);
      bus_in_x = (b == 3) ? ~card : 8'($urandom);
      int_x    = 1'($urandom_range(0, 1));
      drive    = !(b == 3 && !w);
      chk("clk_rw", {7'd0, clk_rw}, {7'd0, ph >= HP});
      chk("ax_d", {7'd0, ax_d}, {7'd0, !(b == 0 || b == 1 || b == 4)});
      chk("r_wx", {7'd0, r_wx}, {7'd0, !(b == 1 || b == 2 || (b == 3 && w))});
      chk("slot", {7'd0, slot_x_int_x}, {7'd0, !init});
      chk("oe", {7'd0, bus_oe_x}, {7'd0, !drive});
      if (drive) chk("bus_out", bus_out_x, ~bytes[b]);
      chk("rsp_valid_mid", {7'd0, rsp_valid}, 8'd0);
      chk("busy_mid", {7'd0, busy}, 8'd1);
      step();
    end
    chk("rsp_valid_end", {7'd0, rsp_valid}, 8'd1);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("ready_in_rsp", {7'd0, req_ready}, 8'd0);
    chk_idle("end");
    int_x = 1'b1;
    step();
    chk("rsp_valid_after", {7'd0, rsp_valid}, 8'd0);
    chk("ready_after", {7'd0, req_ready}, 8'd1);
    chk("busy_after", {7'd0, busy}, 8'd0);
    chk("rdata_hold", rsp_rdata, exp_rd);
    chk_idle("after");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_init = 1'b0;
    req_cmd = 8'h00; req_reg = 8'h00; req_wdata = 8'h00; bus_in_x = 8'hFF; int_x = 1'b1;
    #25;
    chk_idle("reset");
    chk("reset_ready", {7'd0, req_ready}, 8'd1);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("reset_rdata", rsp_rdata, 8'h00);
    chk("reset_irq", {7'd0, irq_pending}, 8'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("quiet_clk_rw", {7'd0, clk_rw}, 8'd1);
      chk("quiet_rsp", {7'd0, rsp_valid}, 8'd0);
    end

    run_txn(1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h88, 1'b0);
    run_txn(1'b1, 1'b0, 8'h21, 8'h00, 8'h04, 8'h00, 1'b0);
    run_txn(1'b1, 1'b1, 8'h10, 8'h03, 8'h02, 8'h00, 1'b0);

    // Back-to-back with req_valid held high across the first response.
    run_txn(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
    run_txn(1'b1, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

    for (int i = 0; i < 6; i++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom), 1'b0);

    // Interrupt synchroniser latency.
    int_x = 1'b0;
    step();
    chk("irq_lag1", {7'd0, irq_pending}, 8'd0);
    step(); step();
    chk("irq_set", {7'd0, irq_pending}, 8'd1);
    int_x = 1'b1;
    step(); step(); step();
    chk("irq_clear", {7'd0, irq_pending}, 8'd0);

    // Reset in the middle of a read.
    req_write = 1'b0; req_init = 1'b0; req_cmd = 8'h20; req_reg = 8'h05;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 1; c < 120; c++) step();
    chk("pre_reset_busy", {7'd0, busy}, 8'd1);
    #5;
    rst = 1'b1;
    int_x = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_ready", {7'd0, req_ready}, 8'd1);
    chk("async_rst_rsp", {7'd0, rsp_valid}, 8'd0);
    chk("async_rst_rdata", rsp_rdata, 8'h00);
    chk("async_rst_irq", {7'd0, irq_pending}, 8'd0);
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    chk("irq_after_rst", {7'd0, irq_pending}, 8'd1);
    for (int i = 0; i < 300; i++) begin
      chk("dropped_rsp", {7'd0, rsp_valid}, 8'd0);
      chk("dropped_clk_rw", {7'd0, clk_rw}, 8'd1);
      step();
    end
    int_x = 1'b1;
    step(); step(); step();
    run_txn(1'b0, 1'b1, 8'h22, 8'h07, 8'h00, 8'h5A, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
